// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the shared-multiplier arbiter: FSM states,
// default sizes and the round-robin grant search.
package mult_share_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int N_REQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // First set request at or after ptr, searching upward with wrap-around over n requesters.
    function automatic logic [2:0] rr_grant(input logic [7:0] req, input logic [2:0] ptr,
                                            input int unsigned n);
        logic [2:0]  g;
        logic        found;
        int unsigned idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = (32'(ptr) + i) % n;
            if (!found && (i < n) && req[idx[2:0]]) begin
                g     = idx[2:0];
                found = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mult_iter_core.sv
// Iterative shift-add multiplier datapath, one multiplier bit per cycle.
// MULT_SHARE_ARB_EARLY_EXIT_EN: also finish as soon as the remaining multiplier bits are zero.
module mult_iter_core
    import mult_share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] a_sh_q, a_sh_d, acc_q, acc_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               active_q, active_d;
    logic               last;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        last     = 1'b0;
        if (start) begin
            a_sh_d   = {{WIDTH{1'b0}}, a};
            b_sh_d   = b;
            acc_d    = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            acc_d  = acc_q + (b_sh_q[0] ? a_sh_q : '0);
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            last   = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MULT_SHARE_ARB_EARLY_EXIT_EN
            last   = last || (b_sh_d == '0);
`endif
            active_d = !last;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    // The final product is the accumulator value being written on the last step.
    assign done = last;
    assign p    = acc_d;

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one iterative multiplier between N_REQ requesters.
// MULT_SHARE_ARB_EARLY_EXIT_EN (in mult_iter_core) shortens CALC for small multipliers.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_p,
    output logic                   busy
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, grant;
    logic               rsp_valid_q, rsp_valid_d, busy_q, busy_d;
    logic [2*WIDTH-1:0] rsp_p_q, rsp_p_d, core_p;
    logic [WIDTH-1:0]   op_a, op_b;
    logic               start, core_done;

    assign grant = ID_W'(rr_grant(8'(req_valid), 3'(rr_ptr_q), N_REQ));
    assign op_a  = req_a[grant*WIDTH +: WIDTH];
    assign op_b  = req_b[grant*WIDTH +: WIDTH];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_p_d     = rsp_p_q;
        start       = 1'b0;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    start            = 1'b1;
                    req_ready[grant] = !rst;
                    id_d             = grant;
                    rr_ptr_d         = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
                    state_d          = CALC;
                end
            end
            CALC: begin
                if (core_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_p_d     = core_p;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_p_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_p_q     <= rsp_p_d;
            busy_q      <= busy_d;
        end
    end

    mult_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (op_a),
        .b     (op_b),
        .done  (core_done),
        .p     (core_p)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_p     = rsp_p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: grant model plus a scoreboard of expected responses.
module tb_mult_share_arb;
    import mult_share_pkg::*;

    localparam int W   = WIDTH_DEF;
    localparam int N   = N_REQ_DEF;
    localparam int IDW = $clog2(N);

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [2*W-1:0]   rsp_p;
    logic             busy;

    mult_share_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             id;
        logic [2*W-1:0] p;
        int             due;
    } exp_t;

    exp_t sb[$];
    int   accept_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    int   n_rsp   = 0;
    int   model_ptr = 0;
    bit   rel_pend  = 1'b0;
    int   rel_id    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic int exp_calc(input logic [W-1:0] b);
        int calc;
        calc = W;
`ifdef MULT_SHARE_ARB_EARLY_EXIT_EN
        calc = 1;
        for (int i = 0; i < W; i++) if (b[i]) calc = i + 1;
`endif
        return calc;
    endfunction

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    // Sample at the falling edge, then let the requester release after the grant edge.
    task automatic step();
        logic [N-1:0] exp_ready;
        bit           exp_busy;
        int           g;
        exp_t         e;
        @(negedge clk);
        cycle++;
        exp_busy = (sb.size() != 0);
        check("busy", 64'(busy), 64'(exp_busy));
        if (sb.size() != 0 && cycle > sb[0].due) begin
            check("rsp_late", 64'(0), 64'(1));
            void'(sb.pop_front());
        end
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_p", rsp_p, e.p);
                check("rsp_cycle", 64'(cycle), 64'(e.due));
                n_rsp++;
            end
        end
        exp_ready = '0;
        g = 0;
        if (!exp_busy && !rst && (|req_valid)) begin
            g = model_grant();
            exp_ready[g] = 1'b1;
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        if (exp_ready != '0) begin
            e.id  = g;
            e.p   = {{W{1'b0}}, req_a[g*W +: W]} * {{W{1'b0}}, req_b[g*W +: W]};
            e.due = cycle + exp_calc(req_b[g*W +: W]) + 1;
            sb.push_back(e);
            model_ptr = (g + 1) % N;
            rel_pend  = 1'b1;
            rel_id    = g;
            accept_log.push_back(cycle);
        end
        @(posedge clk);
        #1;
        if (rel_pend) begin
            req_valid[rel_id] = 1'b0;
            rel_pend = 1'b0;
        end
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while ((sb.size() != 0 || (|req_valid)) && k < max_cycles) begin
            step();
            k++;
        end
        if (k >= max_cycles) check("drain_timeout", 64'(1), 64'(0));
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return W'(1) << $urandom_range(0, W - 1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int target;
        int guard;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) set_req(i, W'(i + 1), W'(32'h10));
        @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_rsp_p", rsp_p, 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention from reset: grants 0..3, one multiply per exp_calc+2 cycles.
        accept_log.delete();
        drain(400);
        check("contention_accepts", 64'(accept_log.size()), 64'(4));
        for (int i = 1; i < accept_log.size(); i++)
            check("accept_gap", 64'(accept_log[i] - accept_log[i-1]), 64'(exp_calc(W'(32'h10)) + 2));

        // Full-scale operands on requester 0.
        set_req(0, '1, '1);
        drain(100);

        // Round-robin wrap: serve 1 alone (pointer moves to 2), then 3 and 1 together, then 2 and 1.
        set_req(1, W'(7), W'(9));
        drain(100);
        set_req(3, W'(32'h1234), W'(32'h5678));
        set_req(1, W'(32'hABCD), W'(32'h3));
        drain(200);
        set_req(2, W'(5), W'(6));
        set_req(1, W'(8), W'(9));
        drain(200);

        // Edge operands.
        set_req(0, '0, '1);
        drain(100);
        set_req(2, W'(1), W'(32'h8000_0000));
        drain(100);
        set_req(3, W'(32'hDEAD_BEEF), '0);
        drain(100);

        // Reset ten cycles into CALC: outputs clear at once, result discarded.
        accept_log.delete();
        set_req(1, W'(32'hFFFF), W'(32'hFFFF));
        guard = 0;
        while (accept_log.size() == 0 && guard < 20) begin
            step();
            guard++;
        end
        check("mid_accept_seen", 64'(accept_log.size()), 64'(1));
        t0 = cycle;
        while (cycle < t0 + 10) step();
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("mid_rst_rsp_p", rsp_p, 64'(0));
        check("mid_rst_rsp_id", 64'(rsp_id), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_ready", 64'(req_ready), 64'(0));
        sb.delete();
        req_valid = '0;
        rel_pend  = 1'b0;
        model_ptr = 0;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) step();
        set_req(2, W'(32'h8765_4321), W'(32'hFEDC_BA98));
        drain(100);

        // Randomized sweep with overlapping requests.
        target = n_rsp + 1000;
        guard  = 0;
        begin
            int issued;
            issued = 0;
            while (n_rsp < target && guard < 60000) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i] && issued < 1000 && $urandom_range(0, 3) == 0) begin
                        set_req(i, rand_op(), rand_op());
                        issued++;
                    end
                end
                step();
                guard++;
            end
        end
        if (guard >= 60000) check("sweep_timeout", 64'(1), 64'(0));
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
